// File: rtl/mux_case_pkg.sv
// Shared constants for the mux_case block: lane count, select width and select codes.
// The optional select-change detector is enabled with MUX_CASE_SEL_CHG_EN.
package mux_case_pkg;

    localparam int N_IN  = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_I0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_I1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_I2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_I3 = 2'd3;

endpackage

// File: rtl/mux_case_oreg.sv
// Output register stage: registered copy of the selected lane, a sticky valid flag and,
// with MUX_CASE_SEL_CHG_EN defined, a one-cycle pulse whenever the sampled select changes.
module mux_case_oreg
    import mux_case_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    y_d,
`ifdef MUX_CASE_SEL_CHG_EN
    input  logic [SEL_W-1:0] s,
    output logic             sel_chg,
`endif
    output logic [DW-1:0]    y_q,
    output logic             y_vld
);

    logic [DW-1:0] data_d, data_q;
    logic          vld_d, vld_q;

    always_comb begin
        data_d = y_d;
        vld_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign y_q   = data_q;
    assign y_vld = vld_q;

`ifdef MUX_CASE_SEL_CHG_EN
    logic [SEL_W-1:0] s_prev_d, s_prev_q;
    logic             sel_chg_d, sel_chg_q;

    // The stored select is meaningless until one sample has been taken, so gate on valid.
    always_comb begin
        s_prev_d  = s;
        sel_chg_d = vld_q && (s != s_prev_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q  <= '0;
            sel_chg_q <= 1'b0;
        end else begin
            s_prev_q  <= s_prev_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign sel_chg = sel_chg_q;
`endif

endmodule

// File: rtl/mux_case.sv
// Four-lane case-based multiplexer with a combinational output and a registered copy.
// Define MUX_CASE_SEL_CHG_EN to add the sel_chg select-change pulse output.
module mux_case
    import mux_case_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4*DW-1:0]  I,
    input  logic [SEL_W-1:0] S,
`ifdef MUX_CASE_SEL_CHG_EN
    output logic             sel_chg,
`endif
    output logic [DW-1:0]    Y,
    output logic [DW-1:0]    y_q,
    output logic             y_vld
);

    logic [DW-1:0] y_sel;

    // An unknown select matches no code and falls to the default, driving X rather than holding.
    always_comb begin
        y_sel = '0;
        case (S)
            SEL_I0:  y_sel = I[0*DW +: DW];
            SEL_I1:  y_sel = I[1*DW +: DW];
            SEL_I2:  y_sel = I[2*DW +: DW];
            SEL_I3:  y_sel = I[3*DW +: DW];
            default: y_sel = {DW{1'bx}};
        endcase
    end

    assign Y = y_sel;

    mux_case_oreg #(
        .DW(DW)
    ) u_oreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .y_d     (y_sel),
`ifdef MUX_CASE_SEL_CHG_EN
        .s       (S),
        .sel_chg (sel_chg),
`endif
        .y_q     (y_q),
        .y_vld   (y_vld)
    );

endmodule

// File: tb/tb_mux_case.sv
// Self-checking bench for mux_case: a DW=1 and a DW=8 instance share clock, reset and select.
// Define MUX_CASE_SEL_CHG_EN to also exercise the select-change pulse.
module tb_mux_case;

    logic       clk;
    logic       rst_n;
    logic [3:0] i1;
    logic [31:0] i8;
    logic [1:0] s;
    logic       y1, yq1, vld1;
    logic [7:0] y8, yq8;
    logic       vld8;
`ifdef MUX_CASE_SEL_CHG_EN
    logic       chg1, chg8;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic       exp_q[$];
    logic [7:0] exp8_q[$];

    mux_case #(.DW(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .I       (i1),
        .S       (s),
`ifdef MUX_CASE_SEL_CHG_EN
        .sel_chg (chg1),
`endif
        .Y       (y1),
        .y_q     (yq1),
        .y_vld   (vld1)
    );

    mux_case #(.DW(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .I       (i8),
        .S       (s),
`ifdef MUX_CASE_SEL_CHG_EN
        .sel_chg (chg8),
`endif
        .Y       (y8),
        .y_q     (yq8),
        .y_vld   (vld8)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (got timeout, want finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pick lane sel of a packed vector.
    function automatic logic model1(input logic [3:0] v, input logic [1:0] sel);
        return v[sel];
    endfunction

    function automatic logic [7:0] model8(input logic [31:0] v, input logic [1:0] sel);
        logic [31:0] sh;
        sh = v >> (sel * 8);
        return sh[7:0];
    endfunction

    // Drive at negedge, check Y at once, push expected y_q, check it after the next posedge.
    task automatic apply(input logic [3:0] a1, input logic [31:0] a8, input logic [1:0] sel);
        logic       e1;
        logic [7:0] e8;
        @(negedge clk);
        i1 = a1;
        i8 = a8;
        s  = sel;
        #1;
        check_eq("y_comb_dw1", {31'd0, y1}, {31'd0, model1(a1, sel)});
        check_eq("y_comb_dw8", {24'd0, y8}, {24'd0, model8(a8, sel)});
        exp_q.push_back(model1(a1, sel));
        exp8_q.push_back(model8(a8, sel));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0 || exp8_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e1 = exp_q.pop_front();
            e8 = exp8_q.pop_front();
            check_eq("y_q_dw1", {31'd0, yq1}, {31'd0, e1});
            check_eq("y_q_dw8", {24'd0, yq8}, {24'd0, e8});
            check_eq("y_vld", {30'd0, vld1, vld8}, 32'd3);
        end
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(negedge clk);
        s     = sel;
        rst_n = 1'b0;
        #1;
        check_eq("rst_y_q_dw1", {31'd0, yq1}, 32'd0);
        check_eq("rst_y_q_dw8", {24'd0, yq8}, 32'd0);
        check_eq("rst_y_vld", {30'd0, vld1, vld8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        i1    = 4'b0000;
        i8    = 32'h0;
        s     = 2'b00;
        #1;
        check_eq("reset_y_q", {23'd0, yq1, yq8}, 32'd0);
        check_eq("reset_y_vld", {30'd0, vld1, vld8}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: all zero lanes, and y_vld rises at the first edge after release
        apply(4'b0000, 32'h0, 2'b00);

        // Scenario 2: walking one follows the select
        apply(4'b0001, 32'h0000_00FF, 2'b00);
        apply(4'b0010, 32'h0000_FF00, 2'b01);
        apply(4'b0100, 32'h00FF_0000, 2'b10);
        apply(4'b1000, 32'hFF00_0000, 2'b11);

        // Scenario 3: unselected lanes are ignored
        for (int k = 0; k < 4; k++) apply(4'b1110, 32'h4433_2211, 2'(k));
        apply(4'b0001, 32'h0000_0011, 2'b01);

        // Scenario 6: byte lanes
        apply(4'b0100, 32'hDDCC_BBAA, 2'b10);
        check_eq("scn6_y_q", {24'd0, yq8}, 32'h0000_00CC);

        // Scenario 4: async reset between edges while y_q=1
        apply(4'b1000, 32'hDDCC_BBAA, 2'b11);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_y_q", {23'd0, yq1, yq8}, 32'd0);
        check_eq("async_rst_y_vld", {30'd0, vld1, vld8}, 32'd0);
        check_eq("async_rst_y_dw1", {31'd0, y1}, 32'd1);
        check_eq("async_rst_y_dw8", {24'd0, y8}, 32'h0000_00DD);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_y_vld", {30'd0, vld1, vld8}, 32'd3);
        check_eq("post_rst_y_q", {23'd0, yq1, yq8}, {23'd0, 1'b1, 8'hDD});

        // Inputs that change between edges: only the value at the edge is captured
        @(negedge clk);
        i1 = 4'b0001;
        s  = 2'b00;
        #2;
        i1 = 4'b0000;
        #1;
        i1 = 4'b0100;
        s  = 2'b10;
        @(posedge clk);
        #1;
        check_eq("glitch_y_q", {31'd0, yq1}, 32'd1);

        // Random stimulus
        for (int k = 0; k < 24; k++) begin
            apply(4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)));
        end

`ifdef MUX_CASE_SEL_CHG_EN
        // Scenario 5: first edge after reset is suppressed even though S differs from cleared 0
        do_reset(2'b01);
        @(posedge clk);
        #1;
        check_eq("chg_first_edge", {30'd0, chg1, chg8}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_eq("chg_hold", {30'd0, chg1, chg8}, 32'd0);
        end
        @(negedge clk);
        s = 2'b10;
        @(posedge clk);
        #1;
        check_eq("chg_pulse", {30'd0, chg1, chg8}, 32'd3);
        @(posedge clk);
        #1;
        check_eq("chg_pulse_end", {30'd0, chg1, chg8}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("chg_quiet", {30'd0, chg1, chg8}, 32'd0);
`else
        do_reset(2'b01);
        @(posedge clk);
        #1;
        check_eq("rerst_y_vld", {30'd0, vld1, vld8}, 32'd3);
`endif

        check_eq("sb_drained", 32'(exp_q.size() + exp8_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
